// File: rtl/tone_player.sv
// Square-wave tone player: plays one of three pitches for a fixed duration,
// with retrigger, abort, mute and a one-cycle done pulse on natural completion.
module tone_player #(
  parameter int CLK_HZ = 12000000,
  parameter int DUR_MS = 100,
  parameter int DIV_W  = 16,
  parameter int HALF1  = 13636,
  parameter int HALF2  = 6818,
  parameter int HALF3  = 3409
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] code,
  input  logic       mute,
  output logic       sound,
  output logic       busy,
  output logic       done
);

  localparam int DUR   = DUR_MS * CLK_HZ / 1000;
  localparam int DUR_W = $clog2(DUR);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t           state;
  logic [1:0]       code_q;
  logic [DIV_W-1:0] half_cnt;
  logic [DUR_W-1:0] dur_cnt;
  logic             phase;

  function automatic logic [DIV_W-1:0] half_of(input logic [1:0] c);
    case (c)
      2'd1:    half_of = DIV_W'(HALF1);
      2'd2:    half_of = DIV_W'(HALF2);
      2'd3:    half_of = DIV_W'(HALF3);
      default: half_of = '0;
    endcase
  endfunction

  // A start with a nonzero code always (re)loads the tone, in either state;
  // sound tracks the next phase so the first half-period begins at the start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      code_q   <= '0;
      half_cnt <= '0;
      dur_cnt  <= '0;
      phase    <= 1'b0;
      sound    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && code != 2'd0) begin
        state    <= PLAY;
        code_q   <= code;
        half_cnt <= half_of(code);
        dur_cnt  <= DUR_W'(DUR - 1);
        phase    <= 1'b1;
        busy     <= 1'b1;
        sound    <= ~mute;
      end else if (state == PLAY) begin
        if (start) begin
          state    <= IDLE;
          code_q   <= '0;
          half_cnt <= '0;
          dur_cnt  <= '0;
          phase    <= 1'b0;
          busy     <= 1'b0;
          sound    <= 1'b0;
        end else if (dur_cnt == '0) begin
          state    <= IDLE;
          code_q   <= '0;
          half_cnt <= '0;
          phase    <= 1'b0;
          busy     <= 1'b0;
          sound    <= 1'b0;
          done     <= 1'b1;
        end else begin
          dur_cnt <= dur_cnt - 1'b1;
          if (half_cnt == DIV_W'(1)) begin
            half_cnt <= half_of(code_q);
            phase    <= ~phase;
            sound    <= ~phase & ~mute;
          end else begin
            half_cnt <= half_cnt - 1'b1;
            sound    <= phase & ~mute;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tone_player.sv
// Directed bench for tone_player with a behavioural reference model feeding
// an expected-output queue that is drained after each clock edge.
module tb_tone_player;

  localparam int CLK_HZ = 1000;
  localparam int DUR_MS = 20;
  localparam int DUR    = 20;
  localparam int H1 = 2, H2 = 3, H3 = 5;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] code;
  logic       mute;
  logic       sound, busy, done;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_q[$];

  // reference model state: time since the last start edge
  logic m_busy;
  int   m_t;
  int   m_half;

  tone_player #(
    .CLK_HZ(CLK_HZ), .DUR_MS(DUR_MS), .DIV_W(8),
    .HALF1(H1), .HALF2(H2), .HALF3(H3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .code(code), .mute(mute),
    .sound(sound), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int m_half_of(input int c);
    case (c)
      1:       return H1;
      2:       return H2;
      default: return H3;
    endcase
  endfunction

  task automatic model_reset();
    m_busy = 1'b0;
    m_t    = 0;
    m_half = 1;
  endtask

  task automatic check_output(input string tag, input logic [2:0] expv);
    logic [2:0] obs;
    obs = {sound, busy, done};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed sound/busy/done=%b expected %b at %0t", tag, obs, expv, $time);
    end
  endtask

  // drives one cycle of inputs, predicts the post-edge outputs, then compares
  task automatic apply_stimulus(input string tag, input logic s, input logic [1:0] c, input logic m);
    logic       e_done;
    logic       e_sound;
    logic [2:0] expv;
    start = s;
    code  = c;
    mute  = m;
    e_done = 1'b0;
    if (s && c != 2'd0) begin
      m_busy = 1'b1;
      m_t    = 0;
      m_half = m_half_of(int'(c));
    end else if (s && m_busy) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_t++;
      if (m_t == DUR) begin
        m_busy = 1'b0;
        e_done = 1'b1;
      end
    end
    e_sound = m_busy && ((m_t / m_half) % 2 == 0) && !m;
    exp_q.push_back({e_sound, m_busy, e_done});
    @(posedge clk);
    #1;
    checks++;
    assert (exp_q.size() == 1) else begin
      errors++;
      $error("[TB] FAIL %s queue: observed depth %0d expected 1", tag, exp_q.size());
    end
    if (exp_q.size() > 0) check_output(tag, exp_q.pop_front());
  endtask

  task automatic idle_cycles(input string tag, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(tag, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    code  = 2'd0;
    mute  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_state", 3'b000);
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] idle after reset");
    idle_cycles("idle50", 50);

    $display("[TB] start with code 0 ignored");
    apply_stimulus("start_code0", 1'b1, 2'd0, 1'b0);
    idle_cycles("after_code0", 2);

    $display("[TB] pong full tone");
    apply_stimulus("pong_e0", 1'b1, 2'd1, 1'b0);
    idle_cycles("pong", 24);

    $display("[TB] ping retriggered to go");
    apply_stimulus("ping_e0", 1'b1, 2'd2, 1'b0);
    idle_cycles("ping", 6);
    apply_stimulus("retrig_e7", 1'b1, 2'd3, 1'b0);
    idle_cycles("go_after_retrig", 24);

    $display("[TB] abort");
    apply_stimulus("abort_e0", 1'b1, 2'd1, 1'b0);
    idle_cycles("abort_play", 4);
    apply_stimulus("abort_e5", 1'b1, 2'd0, 1'b0);
    idle_cycles("after_abort", 5);

    $display("[TB] mute window");
    apply_stimulus("mute_e0", 1'b1, 2'd3, 1'b0);
    idle_cycles("mute_pre", 2);
    for (int i = 3; i <= 9; i++) apply_stimulus("muted", 1'b0, 2'd0, 1'b1);
    idle_cycles("mute_post", 14);

    $display("[TB] start on natural end edge");
    apply_stimulus("edge_e0", 1'b1, 2'd1, 1'b0);
    idle_cycles("edge_play", 19);
    apply_stimulus("edge_e20_restart", 1'b1, 2'd2, 1'b0);
    idle_cycles("edge_second", 22);

    $display("[TB] start muted");
    apply_stimulus("muted_start", 1'b1, 2'd2, 1'b1);
    idle_cycles("muted_start_run", 4);
    apply_stimulus("muted_abort", 1'b1, 2'd0, 1'b0);

    $display("[TB] async reset mid tone");
    apply_stimulus("rst_e0", 1'b1, 2'd2, 1'b0);
    idle_cycles("rst_play", 8);
    #4 rst_n = 1'b0;
    model_reset();
    #1;
    check_output("async_reset", 3'b000);
    repeat (2) begin
      @(posedge clk);
      #1;
      check_output("in_reset", 3'b000);
    end
    #4 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_output("reset_released", 3'b000);
    apply_stimulus("post_rst_e0", 1'b1, 2'd1, 1'b0);
    idle_cycles("post_rst", 24);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_player.md
TONE_PLAYER -- requirements
Module: tone_player

Interface
REQ-001 Parameter CLK_HZ, default 12000000, system clock frequency in Hz.
REQ-002 Parameter DUR_MS, default 100, tone duration in ms; DUR = DUR_MS*CLK_HZ/1000 cycles, integer, >= 2.
REQ-003 Parameter DIV_W, default 16, width of half-period counter.
REQ-004 Parameter HALF1, default 13636, half-period in cycles for code 1 (pong, 440 Hz at default clock); >= 1.
REQ-005 Parameter HALF2, default 6818, half-period in cycles for code 2 (ping, 880 Hz); >= 1.
REQ-006 Parameter HALF3, default 3409, half-period in cycles for code 3 (go, 1760 Hz); >= 1.
REQ-007 clk  in  1  system clock, all state on rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  request: play code; sampled every rising edge.
REQ-010 code  in  2  sound code: 0 stop, 1 pong, 2 ping, 3 go; sampled only with start=1.
REQ-011 mute  in  1  silence output; timing unaffected.
REQ-012 sound  out  1  registered square-wave audio output.
REQ-013 busy  out  1  registered; high while a tone is playing.
REQ-014 done  out  1  registered one-cycle pulse on natural end of a tone.

Function
REQ-015 FSM states IDLE, PLAY; register widths: half counter DIV_W bits, duration counter $clog2(DUR) bits, no overflow.
REQ-016 IDLE, start=1, code!=0: at that edge (E0), latch code, load half counter with HALF[code], load duration counter with DUR-1, phase=1, go PLAY; busy=1 and sound=~mute from E0.
REQ-017 IDLE, start=1, code=0: ignored, outputs stay 0.
REQ-018 PLAY: phase toggles every HALF[latched code] cycles, giving sound pattern of HALF ones then HALF zeros, repeating, from E0.
REQ-019 PLAY: duration counter decrements each cycle; edge at which it is 0 (E0+DUR) -> IDLE, busy=0, sound=0, done=1 for exactly one cycle.
REQ-020 busy is high for exactly DUR cycles per uninterrupted tone.
REQ-021 PLAY, start=1, code!=0 (retrigger): identical to REQ-016 with new code; busy stays 1; no done pulse for the interrupted tone.
REQ-022 PLAY, start=1, code=0 (abort): next edge -> IDLE, sound=0, busy=0, done=0.
REQ-023 Simultaneous start and natural end on the same edge: start wins (REQ-021/022), no done.
REQ-024 sound register loads phase AND NOT mute every edge; mute takes effect one cycle after sampling; phase and duration keep running while muted.
REQ-025 done never asserted in two consecutive cycles; sound=0 whenever busy=0.

Reset
REQ-026 rst_n=0 asynchronously forces IDLE, sound=0, busy=0, done=0, all counters 0, latched code 0, independent of clk.
REQ-027 Reset mid-PLAY aborts tone with no done pulse; first start after rst_n rises is handled per REQ-016.

Verification (CLK_HZ=1000, DUR_MS=20 -> DUR=20, HALF1=2, HALF2=3, HALF3=5)
REQ-028 rst_n=0 then 1, no start -> sound=0, busy=0, done=0 for 50 cycles.
REQ-029 start pulse code=1 at E0 -> sound 1,1,0,0,1,1,... for 20 cycles, busy=1 for 20 cycles, at E20 busy=0, sound=0, done=1 one cycle.
REQ-030 code=2 at E0, start code=3 at E7 -> busy continuous 27 cycles, sound from E7 is 5 ones/5 zeros, single done at E27.
REQ-031 code=1 at E0, start code=0 at E5 -> at E5 sound=0, busy=0, done never asserts.
REQ-032 code=3 at E0, mute=1 during E3..E9 -> sound=0 cycles E3..E9, resumes matching phase from E10, done still at E20.
REQ-033 code=2 at E0, rst_n=0 at E8+half cycle -> all outputs 0 immediately, no done; new start code=1 afterward follows REQ-029.
